mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter CANCEL_W, default 2: width of the discarded-response counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ws_allowin  input  1  WB stage can accept this cycle.
REQ-005 SHALL have port ms_allowin  output  1  MEM stage can accept from pre_MEM this cycle.
REQ-006 SHALL have port pms_to_ms_bus  input  pms_to_ms_bus_t  pre_MEM payload: valid, load_op, c0_op, c0_addr, req_ok, res_from_mem, res_to_mem, rf_we, dest, result, pc, exception, phy_addr, tlb_op, cache_op.
REQ-007 SHALL have port ms_to_ws_bus  output  ms_to_ws_bus_t  WB payload: valid, rf_we, dest, final_result, pc, c0_op, c0_addr, exception, tlb_op, cache_op.
REQ-008 SHALL have port ms_forward_bus  output  ms_forward_bus_t  {op_mfc0, load_pending, op_tlb_cache, dest, final_result}.
REQ-009 SHALL have port pipeline_flush  input  pipeline_flush_t  flush request; .flush is the kill bit.
REQ-010 SHALL have port ms_wr_disable  output  1  blocks younger memory requests in pre_MEM.
REQ-011 SHALL have port data_data_ok  input  1  data SRAM-like response strobe, loads and stores.
REQ-012 SHALL have port data_rdata  input  32  read data, valid with data_data_ok.

Function
REQ-013 SHALL hold ms_valid and payload register bus_r; on ms_allowin, ms_valid <= pms_to_ms_bus.valid; bus_r captured only when pms_to_ms_bus.valid && ms_allowin.
REQ-014 SHALL treat bus_r.req_ok=1 as one outstanding access awaiting exactly one data_data_ok.
REQ-015 SHALL define ms_ready_go = !bus_r.req_ok || data_ok_live || buf_valid; data_ok_live = data_data_ok && cancel_cnt==0.
REQ-016 SHALL drive ms_allowin = !ms_valid || (ms_ready_go && ws_allowin); ms_to_ws_bus.valid = ms_valid && ms_ready_go.
REQ-017 SHALL, when data_ok_live arrives while ms_valid, waiting, and !ws_allowin, latch data_rdata into rdata_buf and set buf_valid; buf_valid clears when the instruction leaves (ms_allowin) or on flush.
REQ-018 SHALL select raw data = buf_valid ? rdata_buf : data_rdata.
REQ-019 SHALL extract load data by bus_r.result[1:0]: LB/LBU byte lane sign/zero-extended; LH/LHU half-word at offset 0 or 2; LW whole word; non-load final_result = bus_r.result.
REQ-020 SHALL, on pipeline_flush.flush, clear ms_valid and buf_valid next cycle, regardless of ws_allowin.
REQ-021 SHALL, on flush, add to cancel_cnt: +1 if ms_valid && bus_r.req_ok && !data_ok_live && !buf_valid; +1 if pms_to_ms_bus.valid && pms_to_ms_bus.req_ok && ms_allowin; max +2 per cycle.
REQ-022 SHALL, while cancel_cnt>0, discard each data_data_ok and decrement cancel_cnt by 1; increment and decrement in the same cycle SHALL net.
REQ-023 SHALL saturate-never: cancel_cnt SHALL NOT exceed 2^CANCEL_W-1 (assert).
REQ-024 SHALL drive ms_wr_disable = ms_valid && bus_r.exception.ex.
REQ-025 SHALL drive forward bus: dest = bus_r.dest & {5{ms_valid && bus_r.rf_we}}; load_pending = ms_valid && bus_r.res_from_mem && !ms_ready_go; op_mfc0 = ms_valid && bus_r.c0_op[2]; op_tlb_cache = ms_valid && (any tlb_op || cache_op != EMPTY).
REQ-026 SHALL pass exception, pc, c0 and tlb/cache fields unchanged to WB; excepting instructions have req_ok=0 and never wait.

Reset
REQ-027 SHALL on reset clear ms_valid, buf_valid, cancel_cnt; outputs then: ms_allowin=1, ms_to_ws_bus.valid=0, ms_wr_disable=0, forward dest=0, load_pending=0.
REQ-028 SHALL let reset override flush and data_data_ok in the same cycle.

Structure
REQ-029 SHALL take pms_to_ms_bus_t, ms_to_ws_bus_t, ms_forward_bus_t, load_op encoding, exception_t from the shared cpu package; ms_to_ws_bus_t and ms_forward_bus_t are added there.
REQ-030 SHALL place load extraction in one combinational sub-module mem_load_align.

Verification
REQ-031 LW, req_ok=1, data_data_ok one cycle later with 0x8765_4321, ws_allowin=1 -> final_result=0x8765_4321, WB valid that cycle.
REQ-032 LB addr[1:0]=3, rdata=0x80AA_BBCC -> 0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr[1:0]=2 -> 0x0000_80AA.
REQ-033 Response arrives with ws_allowin=0 for 3 cycles -> rdata_buf holds data, buf_valid=1, WB receives buffered value when ws_allowin rises.
REQ-034 Flush while load outstanding and pre_MEM hands over req_ok access same cycle -> cancel_cnt=2; next two data_data_ok discarded, third accepted.
REQ-035 Reset asserted mid-wait with cancel_cnt=1 -> all state zero next cycle, ms_allowin=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared pipeline types for the MEM stage
package mem_stage_pkg;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5
    } load_op_t;

    typedef enum logic [1:0] {
        CACHE_EMPTY      = 2'd0,
        CACHE_ICACHE_INV = 2'd1,
        CACHE_DCACHE_WB  = 2'd2,
        CACHE_DCACHE_INV = 2'd3
    } cache_op_t;

    typedef struct packed {
        logic tlbp;
        logic tlbr;
        logic tlbwi;
    } tlb_op_t;

    typedef struct packed {
        logic        ex;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
    } exception_t;

    typedef struct packed {
        logic        valid;
        load_op_t    load_op;
        logic [2:0]  c0_op;
        logic [7:0]  c0_addr;
        logic        req_ok;
        logic        res_from_mem;
        logic        res_to_mem;
        logic        rf_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
        exception_t  exception;
        logic [31:0] phy_addr;
        tlb_op_t     tlb_op;
        cache_op_t   cache_op;
    } pms_to_ms_bus_t;

    typedef struct packed {
        logic        valid;
        logic        rf_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
        logic [2:0]  c0_op;
        logic [7:0]  c0_addr;
        exception_t  exception;
        tlb_op_t     tlb_op;
        cache_op_t   cache_op;
    } ms_to_ws_bus_t;

    typedef struct packed {
        logic        op_mfc0;
        logic        load_pending;
        logic        op_tlb_cache;
        logic [4:0]  dest;
        logic [31:0] final_result;
    } ms_forward_bus_t;

    typedef struct packed {
        logic        flush;
        logic [31:0] new_pc;
    } pipeline_flush_t;

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - byte/half/word extraction of load data
module mem_load_align
    import mem_stage_pkg::*;
(
    input  load_op_t    load_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw_data,
    input  logic [31:0] result,
    output logic [31:0] final_result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // pick the addressed lane, then extend according to the load type
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = raw_data[7:0];
            2'd1:    byte_sel = raw_data[15:8];
            2'd2:    byte_sel = raw_data[23:16];
            default: byte_sel = raw_data[31:24];
        endcase
        half_sel = addr_lo[1] ? raw_data[31:16] : raw_data[15:0];

        final_result = result;
        case (load_op)
            LD_LB:   final_result = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  final_result = {24'h0, byte_sel};
            LD_LH:   final_result = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  final_result = {16'h0, half_sel};
            LD_LW:   final_result = raw_data;
            default: final_result = result;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage with response buffering and flush cancellation
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int CANCEL_W = 2
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            ws_allowin,
    output logic            ms_allowin,
    input  pms_to_ms_bus_t  pms_to_ms_bus,
    output ms_to_ws_bus_t   ms_to_ws_bus,
    output ms_forward_bus_t ms_forward_bus,
    input  pipeline_flush_t pipeline_flush,
    output logic            ms_wr_disable,
    input  logic            data_data_ok,
    input  logic [31:0]     data_rdata
);

    localparam logic [CANCEL_W:0] CANCEL_MAX = (CANCEL_W+1)'((1 << CANCEL_W) - 1);

    logic                ms_valid;
    pms_to_ms_bus_t      bus_r;
    logic                buf_valid;
    logic [31:0]         rdata_buf;
    logic [CANCEL_W-1:0] cancel_cnt;

    logic                data_ok_live;
    logic                ms_ready_go;
    logic                waiting;
    logic                inc_cur;
    logic                inc_new;
    logic                dec;
    logic [CANCEL_W:0]   cnt_sum;
    logic [31:0]         raw_data;
    logic [31:0]         final_result;
    logic                unused_bits;

    // responses owed to flushed accesses are swallowed before any live one
    assign data_ok_live = data_data_ok && (cancel_cnt == '0);
    assign ms_ready_go  = !bus_r.req_ok || data_ok_live || buf_valid;
    assign ms_allowin   = !ms_valid || (ms_ready_go && ws_allowin);
    assign waiting      = ms_valid && bus_r.req_ok && !buf_valid;
    assign raw_data     = buf_valid ? rdata_buf : data_rdata;

    // count accesses whose responses will arrive after a flush kills them
    always_comb begin
        inc_cur = pipeline_flush.flush && waiting && !data_ok_live;
        inc_new = pipeline_flush.flush && pms_to_ms_bus.valid && pms_to_ms_bus.req_ok && ms_allowin;
        dec     = data_data_ok && (cancel_cnt != '0);
        cnt_sum = {1'b0, cancel_cnt} + (CANCEL_W+1)'(inc_cur) + (CANCEL_W+1)'(inc_new)
                - (CANCEL_W+1)'(dec);
    end

    // stage valid and payload register
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
            bus_r    <= '0;
        end else begin
            if (pipeline_flush.flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= pms_to_ms_bus.valid;
            end
            if (pms_to_ms_bus.valid && ms_allowin) begin
                bus_r <= pms_to_ms_bus;
            end
        end
    end

    // hold a response that arrived while WB was stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            rdata_buf <= '0;
        end else if (pipeline_flush.flush || ms_allowin) begin
            buf_valid <= 1'b0;
        end else if (waiting && data_ok_live && !ws_allowin) begin
            buf_valid <= 1'b1;
            rdata_buf <= data_rdata;
        end
    end

    // outstanding-cancel counter; must never wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            cancel_cnt <= '0;
        end else begin
            assert (cnt_sum <= CANCEL_MAX);
            cancel_cnt <= cnt_sum[CANCEL_W-1:0];
        end
    end

    mem_load_align u_load_align (
        .load_op      (bus_r.load_op),
        .addr_lo      (bus_r.result[1:0]),
        .raw_data     (raw_data),
        .result       (bus_r.result),
        .final_result (final_result)
    );

    // WB payload, forwarding and hazard outputs
    always_comb begin
        ms_to_ws_bus              = '0;
        ms_to_ws_bus.valid        = ms_valid && ms_ready_go;
        ms_to_ws_bus.rf_we        = bus_r.rf_we;
        ms_to_ws_bus.dest         = bus_r.dest;
        ms_to_ws_bus.final_result = final_result;
        ms_to_ws_bus.pc           = bus_r.pc;
        ms_to_ws_bus.c0_op        = bus_r.c0_op;
        ms_to_ws_bus.c0_addr      = bus_r.c0_addr;
        ms_to_ws_bus.exception    = bus_r.exception;
        ms_to_ws_bus.tlb_op       = bus_r.tlb_op;
        ms_to_ws_bus.cache_op     = bus_r.cache_op;

        ms_forward_bus              = '0;
        ms_forward_bus.dest         = bus_r.dest & {5{ms_valid && bus_r.rf_we}};
        ms_forward_bus.load_pending = ms_valid && bus_r.res_from_mem && !ms_ready_go;
        ms_forward_bus.op_mfc0      = ms_valid && bus_r.c0_op[2];
        ms_forward_bus.op_tlb_cache = ms_valid && ((|bus_r.tlb_op) || (bus_r.cache_op != CACHE_EMPTY));
        ms_forward_bus.final_result = final_result;

        ms_wr_disable = ms_valid && bus_r.exception.ex;
    end

    assign unused_bits = ^{bus_r.valid, bus_r.res_to_mem, bus_r.phy_addr, pipeline_flush.new_pc};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            ws_allowin;
    logic            ms_allowin;
    pms_to_ms_bus_t  pms;
    ms_to_ws_bus_t   ws_bus;
    ms_forward_bus_t fwd;
    pipeline_flush_t flush;
    logic            ms_wr_disable;
    logic            data_data_ok;
    logic [31:0]     data_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage #(.CANCEL_W(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .ws_allowin     (ws_allowin),
        .ms_allowin     (ms_allowin),
        .pms_to_ms_bus  (pms),
        .ms_to_ws_bus   (ws_bus),
        .ms_forward_bus (fwd),
        .pipeline_flush (flush),
        .ms_wr_disable  (ms_wr_disable),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic pms_to_ms_bus_t mk_ld(input load_op_t op, input logic [31:0] addr,
                                             input logic [31:0] pc);
        pms_to_ms_bus_t b;
        b              = '0;
        b.valid        = 1'b1;
        b.load_op      = op;
        b.req_ok       = 1'b1;
        b.res_from_mem = (op != LD_NONE);
        b.rf_we        = 1'b1;
        b.dest         = 5'd7;
        b.result       = addr;
        b.phy_addr     = addr;
        b.pc           = pc;
        return b;
    endfunction

    // reference: shift the word down to the addressed lane, then extend arithmetically
    function automatic logic [31:0] ref_result(input load_op_t op, input logic [31:0] addr,
                                               input logic [31:0] word);
        logic [31:0] lane_b;
        logic [31:0] lane_h;
        int unsigned off;
        off    = addr % 4;
        lane_b = (word >> (8 * off)) % 256;
        lane_h = (word >> (8 * (off / 2) * 2)) % 65536;
        case (op)
            LD_LB:   return (lane_b >= 128) ? lane_b - 256 : lane_b;
            LD_LBU:  return lane_b;
            LD_LH:   return (lane_h >= 32768) ? lane_h - 65536 : lane_h;
            LD_LHU:  return lane_h;
            LD_LW:   return word;
            default: return addr;
        endcase
    endfunction

    // single load with response one cycle after entry, WB always ready
    task automatic run_load(input string tag, input load_op_t op, input logic [31:0] addr,
                            input logic [31:0] word, input logic [31:0] exp);
        pms = mk_ld(op, addr, 32'hBFC0_0100);
        ws_allowin = 1'b1;
        tick();
        pms.valid = 1'b0;
        settle();
        check({tag, "_pending"}, 32'(fwd.load_pending), 32'd1);
        check({tag, "_wait"}, 32'(ws_bus.valid), 32'd0);
        data_data_ok = 1'b1;
        data_rdata   = word;
        settle();
        check({tag, "_valid"}, 32'(ws_bus.valid), 32'd1);
        check({tag, "_result"}, ws_bus.final_result, exp);
        tick();
        data_data_ok = 1'b0;
        settle();
        check({tag, "_gone"}, 32'(ws_bus.valid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        ws_allowin   = 1'b1;
        pms          = '0;
        flush        = '0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        tick();
        tick();
        check("rst_allowin", 32'(ms_allowin), 32'd1);
        check("rst_valid", 32'(ws_bus.valid), 32'd0);
        check("rst_wr_dis", 32'(ms_wr_disable), 32'd0);
        check("rst_fwd_dest", 32'(fwd.dest), 32'd0);
        check("rst_pending", 32'(fwd.load_pending), 32'd0);
        reset = 1'b0;
        settle();

        run_load("lw", LD_LW, 32'h1000_0000, 32'h8765_4321, 32'h8765_4321);
        run_load("lb3", LD_LB, 32'h1000_0003, 32'h80AA_BBCC, 32'hFFFF_FF80);
        run_load("lbu3", LD_LBU, 32'h1000_0003, 32'h80AA_BBCC, 32'h0000_0080);
        run_load("lhu2", LD_LHU, 32'h1000_0002, 32'h80AA_BBCC, 32'h0000_80AA);
        run_load("lh0", LD_LH, 32'h1000_0000, 32'h1234_F00D, 32'hFFFF_F00D);

        // response while WB stalled for three cycles
        pms = mk_ld(LD_LW, 32'h0000_0020, 32'hBFC0_0200);
        ws_allowin = 1'b1;
        tick();
        pms.valid    = 1'b0;
        ws_allowin   = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEAD_BEEF;
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'h1111_1111;
        settle();
        check("buf_valid", 32'(dut.buf_valid), 32'd1);
        check("buf_data", dut.rdata_buf, 32'hDEAD_BEEF);
        check("buf_stall_allowin", 32'(ms_allowin), 32'd0);
        check("buf_stall_result", ws_bus.final_result, 32'hDEAD_BEEF);
        tick();
        tick();
        ws_allowin = 1'b1;
        settle();
        check("buf_out_valid", 32'(ws_bus.valid), 32'd1);
        check("buf_out_result", ws_bus.final_result, 32'hDEAD_BEEF);
        check("buf_out_allowin", 32'(ms_allowin), 32'd1);
        tick();
        check("buf_cleared", 32'(dut.buf_valid), 32'd0);

        // excepting instruction: no wait, fields pass straight through
        pms = '0;
        pms.valid            = 1'b1;
        pms.exception.ex     = 1'b1;
        pms.exception.excode = 5'h04;
        pms.c0_op            = 3'b100;
        pms.tlb_op.tlbp      = 1'b1;
        pms.pc               = 32'hBFC0_0300;
        tick();
        pms.valid = 1'b0;
        settle();
        check("ex_wr_disable", 32'(ms_wr_disable), 32'd1);
        check("ex_valid", 32'(ws_bus.valid), 32'd1);
        check("ex_excode", 32'(ws_bus.exception.excode), 32'h04);
        check("ex_pc", ws_bus.pc, 32'hBFC0_0300);
        check("ex_mfc0", 32'(fwd.op_mfc0), 32'd1);
        check("ex_tlb_cache", 32'(fwd.op_tlb_cache), 32'd1);
        tick();
        check("ex_wr_disable_off", 32'(ms_wr_disable), 32'd0);

        // flush with a load outstanding, then flush again as pre_MEM hands over an access
        pms = mk_ld(LD_LW, 32'h40, 32'hBFC0_0400);
        tick();
        pms.valid   = 1'b0;
        flush.flush = 1'b1;
        tick();
        check("cnl_first", 32'(dut.cancel_cnt), 32'd1);
        pms          = mk_ld(LD_LW, 32'h44, 32'hBFC0_0404);
        data_data_ok = 1'b1;
        tick();
        check("cnl_net", 32'(dut.cancel_cnt), 32'd1);
        data_data_ok = 1'b0;
        tick();
        check("cnl_two", 32'(dut.cancel_cnt), 32'd2);
        check("cnl_killed", 32'(dut.ms_valid), 32'd0);
        flush.flush = 1'b0;
        pms = mk_ld(LD_LW, 32'h48, 32'hBFC0_0408);
        tick();
        pms.valid    = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hAAAA_0001;
        settle();
        check("cnl_drop1", 32'(ws_bus.valid), 32'd0);
        tick();
        data_rdata = 32'hAAAA_0002;
        settle();
        check("cnl_drop2", 32'(ws_bus.valid), 32'd0);
        tick();
        data_rdata = 32'hAAAA_0003;
        settle();
        check("cnl_take_valid", 32'(ws_bus.valid), 32'd1);
        check("cnl_take_data", ws_bus.final_result, 32'hAAAA_0003);
        tick();
        data_data_ok = 1'b0;
        check("cnl_zero", 32'(dut.cancel_cnt), 32'd0);

        // reset mid-wait with a pending cancel, colliding with flush and a response
        pms = mk_ld(LD_LW, 32'h50, 32'hBFC0_0500);
        tick();
        pms.valid   = 1'b0;
        flush.flush = 1'b1;
        tick();
        flush.flush = 1'b0;
        pms = mk_ld(LD_LW, 32'h54, 32'hBFC0_0504);
        tick();
        pms.valid = 1'b0;
        check("rmw_cnt_before", 32'(dut.cancel_cnt), 32'd1);
        reset        = 1'b1;
        flush.flush  = 1'b1;
        data_data_ok = 1'b1;
        tick();
        reset        = 1'b0;
        flush.flush  = 1'b0;
        data_data_ok = 1'b0;
        settle();
        check("rmw_valid", 32'(dut.ms_valid), 32'd0);
        check("rmw_cnt", 32'(dut.cancel_cnt), 32'd0);
        check("rmw_buf", 32'(dut.buf_valid), 32'd0);
        check("rmw_allowin", 32'(ms_allowin), 32'd1);

        // randomized single-instruction traffic with random response delay and WB stalls
        for (int n = 0; n < 80; n++) begin
            load_op_t    op;
            logic [31:0] addr;
            logic [31:0] word;
            logic [31:0] exp;
            logic        req;
            int          delay;
            logic        left;
            op   = load_op_t'($urandom_range(0, 5));
            addr = $urandom;
            if (op == LD_LH || op == LD_LHU) addr = addr - (addr % 2);
            if (op == LD_LW) addr = addr - (addr % 4);
            word  = $urandom;
            req   = (op != LD_NONE) || ($urandom_range(0, 1) == 1);
            exp   = ref_result(op, addr, word);
            delay = $urandom_range(0, 3);
            pms   = mk_ld(op, addr, 32'h8000_0000 + 32'(n * 4));
            pms.req_ok = req;
            ws_allowin   = 1'b1;
            data_data_ok = 1'b0;
            tick();
            pms.valid = 1'b0;
            left = 1'b0;
            for (int cyc = 0; cyc < 40 && !left; cyc++) begin
                logic exp_v;
                ws_allowin   = (cyc >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
                data_data_ok = req && (cyc == delay);
                data_rdata   = data_data_ok ? word : $urandom;
                exp_v        = !req || (cyc >= delay);
                settle();
                check("rnd_valid", 32'(ws_bus.valid), 32'(exp_v));
                check("rnd_pending", 32'(fwd.load_pending), 32'((op != LD_NONE) && !exp_v));
                if (ws_bus.valid && ws_allowin) begin
                    check("rnd_result", ws_bus.final_result, exp);
                    check("rnd_pc", ws_bus.pc, 32'h8000_0000 + 32'(n * 4));
                    left = 1'b1;
                end
                tick();
            end
            data_data_ok = 1'b0;
            if (!left) check("rnd_timeout", 32'd0, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
